// File: rtl/vga_pkg.sv
// vga_pkg: 800x600 display geometry and overlay rectangle constants
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int VER_BLANK_START = 600;
  localparam int RECT_WIDTH = 48;
  localparam int RECT_HEIGHT = 64;
  localparam int RECT_ADDR_W = 12;
  localparam int RECT_COORD_W = 6;
endpackage

// File: rtl/delay.sv
// delay: WIDTH-bit shift register delaying d by CLK_DEL clocks, sync reset to zero
module delay #(
  parameter int WIDTH = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [CLK_DEL];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
    end
  end
  assign q = stage[CLK_DEL-1];
endmodule

// File: rtl/draw_rect.sv
// draw_rect: overlays a ROM-sourced image rectangle onto the VGA pixel stream, 2 clk latency
module draw_rect
  import vga_pkg::*;
#(
  parameter int RECT_W = RECT_WIDTH,
  parameter int RECT_H = RECT_HEIGHT,
  parameter bit TRANSP_EN = 1'b1,
  parameter logic [11:0] TRANSP_COLOR = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic [10:0]            vcount_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  input  logic [10:0]            xpos,
  input  logic [10:0]            ypos,
  output logic [RECT_ADDR_W-1:0] pixel_addr,
  input  logic [11:0]            rgb_pixel,
  output logic [10:0]            hcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic [10:0]            vcount_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out
);
  localparam logic [10:0] X_MAX = 11'(HOR_PIXELS - RECT_W);
  localparam logic [10:0] Y_MAX = 11'(VER_PIXELS - RECT_H);
  logic [10:0] xpos_q, ypos_q, col, row;
  logic [11:0] rgb_q, rgb_d;
  logic hit, in_rect, in_rect_d;
  assign col = hcount_in - xpos_q;
  assign row = vcount_in - ypos_q;
  assign hit = (hcount_in >= xpos_q) && (hcount_in < xpos_q + 11'(RECT_W)) &&
               (vcount_in >= ypos_q) && (vcount_in < ypos_q + 11'(RECT_H)) && !hblnk_in && !vblnk_in;
  // position is latched once per frame so a moving rectangle never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
      in_rect <= 1'b0;
      rgb_q <= '0;
      pixel_addr <= '0;
    end else begin
      if (vcount_in == 11'(VER_BLANK_START) && hcount_in == '0) begin
        xpos_q <= (xpos > X_MAX) ? X_MAX : xpos;
        ypos_q <= (ypos > Y_MAX) ? Y_MAX : ypos;
      end
      in_rect <= hit;
      rgb_q <= rgb_in;
      pixel_addr <= hit ? {row[RECT_COORD_W-1:0], col[RECT_COORD_W-1:0]} : '0;
    end
  end
  delay #(.WIDTH(26), .CLK_DEL(2)) u_timing (
    .clk(clk),
    .rst(rst),
    .d({hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in}),
    .q({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out})
  );
  delay #(.WIDTH(13), .CLK_DEL(1)) u_rgb (
    .clk(clk),
    .rst(rst),
    .d({in_rect, rgb_q}),
    .q({in_rect_d, rgb_d})
  );
  // ROM data arrives in the output cycle, so the final mux is combinational on it
  assign rgb_out = (hblnk_out || vblnk_out) ? 12'h000 :
                   (in_rect_d && !(TRANSP_EN && rgb_pixel == TRANSP_COLOR)) ? rgb_pixel : rgb_d;
endmodule
